// File: rtl/prbs_if.sv
// Receive-side PRBS checker bus: serial bit strobe in, lock/error status out.
// master drives the received stream, slave is the checker.
interface prbs_if #(
   parameter int ERR_W = 16
) ();
   logic             bit_in;
   logic             bit_valid;
   logic             clear_cnt;
   logic             locked;
   logic             err_pulse;
   logic             zero_fill;
   logic [ERR_W-1:0] err_count;
   logic [3:0]       lfsr_state;

   modport master (
      output bit_in, bit_valid, clear_cnt,
      input  locked, err_pulse, zero_fill, err_count, lfsr_state
   );

   modport slave (
      input  bit_in, bit_valid, clear_cnt,
      output locked, err_pulse, zero_fill, err_count, lfsr_state
   );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising 4-bit PRBS checker: seeds a local LFSR from the received
// stream, verifies it, then free-runs and counts mismatches while locked.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FILL   | shifting 4 received bits into r to seed the local LFSR
// S_VERIFY | predicting and self-seeding; needs LOCK_COUNT hits in a row
// S_LOCKED | free-running prediction; mismatches counted, may drop lock
module prbs_checker #(
   parameter int AUG         = 0,
   parameter int LOCK_COUNT  = 8,
   parameter int UNLOCK_ERRS = 4,
   parameter int ERR_W       = 16
) (
   input logic   clk,
   input logic   rst,
   prbs_if.slave bus
);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_ERRS + 1);

   typedef enum logic [1:0] {S_FILL, S_VERIFY, S_LOCKED} state_t;

   state_t           state_q, state_d;
   logic [3:0]       r_q, r_d;
   logic [1:0]       fill_cnt_q, fill_cnt_d;
   logic [GW-1:0]    good_run_q, good_run_d;
   logic [BW-1:0]    bad_q, bad_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic             zero_fill_q, zero_fill_d;

   logic             pred;
   logic             hit;
   logic [3:0]       r_fill;
   logic [GW-1:0]    good_inc;
   logic [BW-1:0]    bad_inc;

   always_comb begin
      pred = (AUG != 0) ? (~(r_q[3] | r_q[2] | r_q[1]) ^ r_q[0] ^ r_q[3])
                        : (r_q[0] ^ r_q[1]);
      hit      = (bus.bit_in == pred);
      r_fill   = {bus.bit_in, r_q[3:1]};
      good_inc = good_run_q + GW'(1);
      bad_inc  = bad_q + BW'(1);

      state_d     = state_q;
      r_d         = r_q;
      fill_cnt_d  = fill_cnt_q;
      good_run_d  = good_run_q;
      bad_d       = bad_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      zero_fill_d = zero_fill_q;

      if (bus.bit_valid) begin
         unique case (state_q)
            S_FILL: begin
               r_d        = r_fill;
               fill_cnt_d = fill_cnt_q + 2'd1;
               if (fill_cnt_q == 2'd3) begin
                  // An all-zero seed is a lockup state of the plain LFSR; refill.
                  if (AUG == 0 && r_fill == 4'b0000) begin
                     zero_fill_d = 1'b1;
                  end else begin
                     zero_fill_d = 1'b0;
                     good_run_d  = '0;
                     state_d     = S_VERIFY;
                  end
               end
            end
            S_VERIFY: begin
               r_d = r_fill;
               if (hit) begin
                  if (good_inc == GW'(LOCK_COUNT)) begin
                     good_run_d = '0;
                     bad_d      = '0;
                     state_d    = S_LOCKED;
                  end else begin
                     good_run_d = good_inc;
                  end
               end else begin
                  good_run_d = '0;
                  fill_cnt_d = 2'd0;
                  state_d    = S_FILL;
               end
            end
            S_LOCKED: begin
               r_d = {pred, r_q[3:1]};
               if (!hit) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + ERR_W'(1);
                  end
                  good_run_d = '0;
                  if (bad_inc == BW'(UNLOCK_ERRS)) begin
                     bad_d      = '0;
                     fill_cnt_d = 2'd0;
                     state_d    = S_FILL;
                  end else begin
                     bad_d = bad_inc;
                  end
               end else if (good_inc == GW'(LOCK_COUNT)) begin
                  good_run_d = '0;
                  bad_d      = '0;
               end else begin
                  good_run_d = good_inc;
               end
            end
            default: state_d = S_FILL;
         endcase
      end

      if (bus.clear_cnt) begin
         err_count_d = '0;
      end
      locked_d = (state_d == S_LOCKED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FILL;
         r_q         <= 4'b0000;
         fill_cnt_q  <= 2'd0;
         good_run_q  <= '0;
         bad_q       <= '0;
         err_count_q <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         zero_fill_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         fill_cnt_q  <= fill_cnt_d;
         good_run_q  <= good_run_d;
         bad_q       <= bad_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         zero_fill_q <= zero_fill_d;
      end
   end

   assign bus.locked     = locked_q;
   assign bus.err_pulse  = err_pulse_q;
   assign bus.zero_fill  = zero_fill_q;
   assign bus.err_count  = err_count_q;
   assign bus.lfsr_state = r_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: plain (4-bit count) and augmented (16-bit count)
// checkers fed the same stimulus and compared against a per-strobe model.
module tb_prbs_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prbs_if #(.ERR_W(4))  if0 ();
   prbs_if #(.ERR_W(16)) if1 ();

   prbs_checker #(.AUG(0), .LOCK_COUNT(8), .UNLOCK_ERRS(4), .ERR_W(4)) dut0 (
      .clk (clk), .rst (rst), .bus (if0.slave));
   prbs_checker #(.AUG(1), .LOCK_COUNT(8), .UNLOCK_ERRS(4), .ERR_W(16)) dut1 (
      .clk (clk), .rst (rst), .bus (if1.slave));

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one entry per checker (index = AUG value).
   int         m_mode [2];   // 0 filling, 1 verifying, 2 locked
   int         m_n    [2];
   int         m_good [2];
   int         m_bad  [2];
   int         m_err  [2];
   logic [3:0] m_w    [2];
   logic       m_zf   [2];
   logic       m_ep   [2];
   int         m_max  [2] = '{15, 65535};

   function automatic logic predict(input logic [3:0] w, input int aug);
      if (aug != 0) return ((w[3:1] == 3'b000) ? 1'b1 : 1'b0) ^ w[0] ^ w[3];
      return w[0] ^ w[1];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_n[k] = 0; m_good[k] = 0; m_bad[k] = 0;
         m_err[k] = 0; m_w[k] = 4'b0000; m_zf[k] = 1'b0; m_ep[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k, input logic bv, input logic b, input logic cc);
      logic p;
      m_ep[k] = 1'b0;
      if (bv) begin
         p = predict(m_w[k], k);
         if (m_mode[k] == 0) begin
            m_w[k] = {b, m_w[k][3:1]};
            m_n[k]++;
            if (m_n[k] == 4) begin
               m_n[k] = 0;
               if (k == 0 && m_w[k] == 4'b0000) m_zf[k] = 1'b1;
               else begin m_zf[k] = 1'b0; m_mode[k] = 1; m_good[k] = 0; end
            end
         end else if (m_mode[k] == 1) begin
            m_w[k] = {b, m_w[k][3:1]};
            if (b == p) begin
               m_good[k]++;
               if (m_good[k] == 8) begin m_good[k] = 0; m_bad[k] = 0; m_mode[k] = 2; end
            end else begin
               m_good[k] = 0; m_n[k] = 0; m_mode[k] = 0;
            end
         end else begin
            m_w[k] = {p, m_w[k][3:1]};
            if (b != p) begin
               m_ep[k] = 1'b1;
               if (m_err[k] < m_max[k]) m_err[k]++;
               m_good[k] = 0;
               m_bad[k]++;
               if (m_bad[k] == 4) begin m_bad[k] = 0; m_n[k] = 0; m_mode[k] = 0; end
            end else begin
               m_good[k]++;
               if (m_good[k] == 8) begin m_good[k] = 0; m_bad[k] = 0; end
            end
         end
      end
      if (cc) m_err[k] = 0;
   endtask

   task automatic check_all();
      check("locked0",    32'(if0.locked),     32'(m_mode[0] == 2));
      check("err_pulse0", 32'(if0.err_pulse),  32'(m_ep[0]));
      check("zero_fill0", 32'(if0.zero_fill),  32'(m_zf[0]));
      check("err_count0", 32'(if0.err_count),  32'(m_err[0]));
      check("lfsr0",      32'(if0.lfsr_state), 32'(m_w[0]));
      check("locked1",    32'(if1.locked),     32'(m_mode[1] == 2));
      check("err_pulse1", 32'(if1.err_pulse),  32'(m_ep[1]));
      check("zero_fill1", 32'(if1.zero_fill),  32'(m_zf[1]));
      check("err_count1", 32'(if1.err_count),  32'(m_err[1]));
      check("lfsr1",      32'(if1.lfsr_state), 32'(m_w[1]));
   endtask

   // Bit sources: the plain 15-bit table and a running augmented generator.
   bit         tbl [15] = '{0,0,1,1,0,1,0,1,1,1,1,0,0,0,1};
   int         pos0 = 0;
   logic [3:0] g1   = 4'b0000;

   task automatic next_bit(input int which, output logic b);
      if (which == 0) begin
         b    = tbl[pos0];
         pos0 = (pos0 + 1) % 15;
      end else begin
         b  = predict(g1, 1);
         g1 = {b, g1[3:1]};
      end
   endtask

   task automatic cyc(input logic bv, input logic b, input logic cc);
      @(negedge clk);
      if0.bit_valid = bv; if0.bit_in = b; if0.clear_cnt = cc;
      if1.bit_valid = bv; if1.bit_in = b; if1.clear_cnt = cc;
      model_step(0, bv, b, cc);
      model_step(1, bv, b, cc);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      if0.bit_valid = 1'b0; if0.bit_in = 1'b0; if0.clear_cnt = 1'b0;
      if1.bit_valid = 1'b0; if1.bit_in = 1'b0; if1.clear_cnt = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      check("rst_locked0", 32'(if0.locked), 32'd0);
      check("rst_lfsr0",   32'(if0.lfsr_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic b;
      int   flips [6] = '{1,0,1,1,0,1};
      int   expc;
      if0.bit_valid = 1'b0; if0.bit_in = 1'b0; if0.clear_cnt = 1'b0;
      if1.bit_valid = 1'b0; if1.bit_in = 1'b0; if1.clear_cnt = 1'b0;
      model_reset();
      do_reset();

      // Plain stream, one strobe every 4th clock.
      pos0 = 0;
      for (int i = 1; i <= 100; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0);
         next_bit(0, b);
         cyc(1'b1, b, 1'b0);
         check("t1_lock", 32'(if0.locked), 32'(i >= 12));
      end
      check("t1_errs", 32'(if0.err_count), 32'd0);

      // Single inverted bit, then clear.
      next_bit(0, b);
      cyc(1'b1, ~b, 1'b0);
      check("t2_pulse", 32'(if0.err_pulse), 32'd1);
      check("t2_count", 32'(if0.err_count), 32'd1);
      check("t2_lock",  32'(if0.locked),    32'd1);
      cyc(1'b0, 1'b0, 1'b0);
      check("t2_pulse_off", 32'(if0.err_pulse), 32'd0);
      cyc(1'b0, 1'b0, 1'b1);
      check("t2_clear", 32'(if0.err_count), 32'd0);
      for (int i = 0; i < 10; i++) begin
         next_bit(0, b);
         cyc(1'b1, b, 1'b0);
      end

      // Burst errors drop lock; repeated bursts drive the 4-bit count to saturation.
      for (int rep = 0; rep < 5; rep++) begin
         for (int j = 0; j < 6; j++) begin
            next_bit(0, b);
            cyc(1'b1, b ^ flips[j][0], 1'b0);
            check("t3_lock_burst", 32'(if0.locked), 32'(j < 5));
         end
         expc = (4 * (rep + 1) > 15) ? 15 : 4 * (rep + 1);
         check("t3_count", 32'(if0.err_count), 32'(expc));
         for (int j = 1; j <= 12; j++) begin
            next_bit(0, b);
            cyc(1'b1, b, 1'b0);
            check("t3_relock", 32'(if0.locked), 32'(j >= 12));
         end
      end

      // Clear coincident with a counted error.
      next_bit(0, b);
      cyc(1'b1, ~b, 1'b1);
      check("t6_clear_wins", 32'(if0.err_count), 32'd0);
      check("t6_pulse",      32'(if0.err_pulse), 32'd1);
      next_bit(0, b);
      cyc(1'b1, b, 1'b0);

      // Asynchronous reset between edges while locked.
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_lock", 32'(if0.locked),     32'd0);
      check("t6_async_cnt",  32'(if0.err_count),  32'd0);
      check("t6_async_lfsr", 32'(if0.lfsr_state), 32'd0);
      do_reset();

      // Stuck-at-zero input.
      for (int i = 1; i <= 24; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         check("t4_zf0",  32'(if0.zero_fill), 32'(i >= 4));
         check("t4_lk0",  32'(if0.locked),    32'd0);
         check("t4_zf1",  32'(if1.zero_fill), 32'd0);
         check("t4_lk1",  32'(if1.locked),    32'd0);
      end

      // Augmented stream, continuous strobes, wraps through 0000 several times.
      do_reset();
      g1 = 4'b0000;
      for (int i = 1; i <= 76; i++) begin
         next_bit(1, b);
         cyc(1'b1, b, 1'b0);
         check("t5_lock", 32'(if1.locked), 32'(i >= 12));
      end
      check("t5_errs", 32'(if1.err_count), 32'd0);

      // Randomised: gaps, bit errors, clears, alternating stream type.
      for (int i = 0; i < 3000; i++) begin
         logic bv, cc, fl;
         bv = ($urandom_range(0, 2) != 0);
         cc = ($urandom_range(0, 39) == 0);
         fl = ($urandom_range(0, 24) == 0);
         if (bv) begin
            next_bit(((i / 500) % 2), b);
            cyc(1'b1, b ^ fl, cc);
         end else begin
            cyc(1'b0, 1'($urandom_range(0, 1)), cc);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
